// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one 4-bit add-with-carry per clock, LS nibble first.
// Result and carry-out land in dedicated output registers with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one nibble added per edge, carry chained through carry_q
// DONE  | S/Co freshly updated, done high for exactly one cycle
`timescale 1ns/1ps
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   Ci,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   S,
  output logic                   Co
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    s_sh_q, s_sh_d;
  logic [W-1:0]    s_q, s_d;
  logic            carry_q, carry_d;
  logic            co_q, co_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [4:0]      t;
  logic [W-1:0]    s_shift;
  logic            last;

  assign t    = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0000, carry_q};
  assign last = (cnt_q == CW'(NIBBLES - 1));

  // A single-nibble sum has no upper part to shift down.
  if (NIBBLES == 1) begin : g_one
    assign s_shift = t[3:0];
  end else begin : g_multi
    assign s_shift = {t[3:0], s_sh_q[W-1:4]};
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_sh_d  = s_shift;
        carry_d = t[4];
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          s_d     = s_shift;
          co_d    = t[4];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Co   = co_q;
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder built on a 4-bit add-with-carry datapath. It latches two `4*NIBBLES`-bit operands and a carry-in on a start request. It then adds one nibble per clock, least-significant first, chaining the carry through a register. It presents the full sum and carry-out with a one-cycle done pulse. It sits directly upstream of the 4-bit adder stage: it sequences operand nibbles into the nibble add and consumes its sum/carry each cycle.

## Interface
Parameters:
- `NIBBLES`, 4, number of 4-bit digits per operand (≥1); operand width W = 4*NIBBLES.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset is synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  W  operand A; captured when start is accepted.
- `B`  in  W  operand B; captured when start is accepted.
- `Ci`  in  1  carry-in to the least-significant nibble; captured with A/B.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; S/Co are valid when high.
- `S`  out  W  sum, A + B + Ci modulo 2^W.
- `Co`  out  1  carry out of the most-significant nibble.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE, start=1: load shift registers a_sh←A, b_sh←B, carry←Ci; clear nibble counter to 0; go to RUN. With start=0, stay in IDLE.
- RUN, each edge:
  - Compute t[4:0] = {1'b0,a_sh[3:0]} + {1'b0,b_sh[3:0]} + carry, a 5-bit result with no truncation before the carry split.
  - Shift t[3:0] into the sum register from the top: s_sh ← {t[3:0], s_sh[W-1:4]}.
  - Set carry ← t[4]; shift a_sh and b_sh right by 4; increment the counter.
  - When the counter was NIBBLES-1 on this edge, go to DONE. On that same edge, S ← final shifted sum and Co ← t[4].
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- start is ignored in RUN and DONE; no queueing.
- S and Co hold their last result until the next completion. They do not change during RUN; internal shift registers are separate from the output registers.
- A, B and Ci may change freely after capture without affecting the result.
- Counter width is max(1, clog2(NIBBLES)).
- rst=1 on any edge, in any state, including mid-RUN:
  - Go to IDLE.
  - Clear S=0, Co=0, busy=0, done=0, carry=0 and the counter.
  - Discard the in-flight operation; no done pulse is produced for it.
- rst has priority over start on the same edge.

## Timing
- Reset values: S=0, Co=0, busy=0, done=0, state IDLE.
- Let start be accepted at edge E0:
  - busy=1 from after E0 through edge E_NIBBLES.
  - Nibble k (k=0..NIBBLES-1) is added at edge E(k+1).
  - done=1, S/Co valid, from after E_NIBBLES for exactly one cycle.
  - Back in IDLE after E_(NIBBLES+1).
- Latency start→done is NIBBLES+1 edges.
- Minimum start-to-start spacing is NIBBLES+2 cycles. A start held high continuously is accepted on the first IDLE edge after DONE.
- NIBBLES=1: one RUN cycle; done appears after the 2nd edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- NIBBLES=4, A=0x1234, B=0x4321, Ci=0, start for one cycle. Required: busy high for 4 cycles, then done pulse with S=0x5555, Co=0.
- A=0xFFFF, B=0x0001, Ci=0. Required: carry ripples through all nibbles; S=0x0000, Co=1.
- A=0xFFFF, B=0xFFFF, Ci=1. Required: S=0xFFFF, Co=1. Then A=0, B=0, Ci=1. Required: S=0x0001, Co=0, with S/Co holding 0xFFFF/1 until the new done.
- Start accepted with A=0x00F0, B=0x0010. Then change A/B and pulse start during RUN. Required: the result is still S=0x0100, Co=0; only one done pulse; no extra operation.
- Assert rst during the 2nd RUN cycle. Required: next cycle busy=0, done=0, S=0, Co=0, state IDLE. A subsequent start with 0x0001+0x0001 yields S=0x0002 after 5 edges.
- NIBBLES=1, A=0xF, B=0x1, Ci=1. Required: done after 2 edges with S=0x1, Co=1.
